inverse_permutation_func: RTL and testbench

Inverse lane-permutation (pi⁻¹) stage of the matrix decoder. It walks a 5x5x64 state held in an external slice memory, one slice per access. For each slice it reads the 25-bit slice word, applies the inverse of the encoder's pi permutation within the slice, and writes the word back to the same address. It undoes the encoder's permutation stage and sits in the decode path in the mirror position of the encoder's permutation.

---
 rtl/inverse_permutation_func.sv | 83 ++++++++
 tb/tb_inverse_permutation_func.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inverse_permutation_func.sv
// Inverse pi lane permutation over a 5x5xSLICES state held in slice memory:
// read each 25-bit slice, apply pi^-1 within the slice, write it back in place.
module inverse_permutation_func #(
  parameter int unsigned SLICES = 64,
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [24:0]       mem_rdata,
  output logic              mem_wr_en,
  output logic [24:0]       mem_wdata
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    SWAP  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(SLICES - 1);

  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic [24:0]       swap_q;
  logic [24:0]       perm;

  // out(x,y) = in(y, (2x+3y) mod 5): pure wiring, bit index 5*y+x
  always_comb begin
    perm = '0;
    for (int unsigned y = 0; y < 5; y++) begin
      for (int unsigned x = 0; x < 5; x++) begin
        perm[5*y+x] = mem_rdata[5*((2*x+3*y)%5)+y];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      swap_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cnt   <= '0;
            state <= READ;
          end
        end
        READ: state <= SWAP;
        SWAP: begin
          swap_q <= perm;
          state  <= WRITE;
        end
        WRITE: begin
          if (cnt == LAST) begin
            state <= DONE;
          end else begin
            cnt   <= cnt + 1'b1;
            state <= READ;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign mem_rd_en = (state == READ);
  assign mem_wr_en = (state == WRITE);
  assign mem_addr  = cnt;
  assign mem_wdata = (state == WRITE) ? swap_q : '0;

endmodule

// File: tb/tb_inverse_permutation_func.sv
// Self-checking bench for inverse_permutation_func against a coordinate-level
// pi / pi^-1 model and a behavioural slice memory.
module tb_inverse_permutation_func;

  logic        clk;
  logic        rst;
  logic        start;
  logic        busy;
  logic        done;
  logic [5:0]  mem_addr;
  logic        mem_rd_en;
  logic [24:0] mem_rdata;
  logic        mem_wr_en;
  logic [24:0] mem_wdata;

  inverse_permutation_func #(.SLICES(64), .ADDR_W(6)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .mem_addr  (mem_addr),
    .mem_rd_en (mem_rd_en),
    .mem_rdata (mem_rdata),
    .mem_wr_en (mem_wr_en),
    .mem_wdata (mem_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [24:0] mem  [64];
  logic [24:0] orig [64];

  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= mem[mem_addr];
    if (mem_wr_en) mem[mem_addr] <= mem_wdata;
  end

  int errors = 0;
  int checks = 0;

  int          rd_cyc[$];
  int          rd_adr[$];
  int          wr_cyc[$];
  int          wr_adr[$];
  logic [24:0] wr_dat[$];
  int          done_cyc[$];
  int          overlap;
  int          end_cyc;
  bit          timed_out;
  bit          abort_nz;

  // Encoder pi: lane (x,y) moves to (y, (2x+3y) mod 5)
  function automatic int pi_dest(input int x, input int y);
    return 5 * ((2 * x + 3 * y) % 5) + y;
  endfunction

  function automatic logic [24:0] fwd_pi(input logic [24:0] w);
    logic [24:0] r = '0;
    for (int y = 0; y < 5; y++)
      for (int x = 0; x < 5; x++)
        r[pi_dest(x, y)] = w[5*y+x];
    return r;
  endfunction

  // Inverse: whatever pi sent to pi_dest(x,y) comes back to (x,y)
  function automatic logic [24:0] inv_pi(input logic [24:0] w);
    logic [24:0] r = '0;
    for (int y = 0; y < 5; y++)
      for (int x = 0; x < 5; x++)
        r[5*y+x] = w[pi_dest(x, y)];
    return r;
  endfunction

  function automatic logic outs_nonzero();
    return busy | done | mem_rd_en | mem_wr_en | (|mem_addr) | (|mem_wdata);
  endfunction

  task automatic do_reset();
    rst   = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic fill_random();
    for (int k = 0; k < 64; k++) begin
      orig[k] = 25'($urandom);
      mem[k]  = orig[k];
    end
  endtask

  // Drives one pass and records strobe activity per cycle (cycle 1 follows the start edge).
  task automatic run_pass(input int abort_at, input int pa, input int pb, input bit hold);
    rd_cyc.delete(); rd_adr.delete(); wr_cyc.delete(); wr_adr.delete();
    wr_dat.delete(); done_cyc.delete();
    overlap = 0; end_cyc = -1; timed_out = 1'b0; abort_nz = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    for (int c = 1; c <= 400; c++) begin
      if (mem_rd_en) begin rd_cyc.push_back(c); rd_adr.push_back(int'(mem_addr)); end
      if (mem_wr_en) begin
        wr_cyc.push_back(c); wr_adr.push_back(int'(mem_addr)); wr_dat.push_back(mem_wdata);
      end
      if (mem_rd_en && mem_wr_en) overlap++;
      if (done) done_cyc.push_back(c);
      if (c == abort_at) begin
        rst = 1'b1;
        #1;
        abort_nz = outs_nonzero();
        end_cyc = c;
        break;
      end
      if (!hold && !busy) begin end_cyc = c; break; end
      if (hold && c == 196) begin end_cyc = c; break; end
      if (!hold) start = (c == pa) || (c == pb);
      @(posedge clk); #1;
    end
    if (end_cyc < 0) timed_out = 1'b1;
    if (!hold) start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (outs_nonzero() !== 1'b0) begin
        errors++; $display("FAIL reset_hold cyc=%0d outputs nonzero busy=%b rd=%b wr=%b addr=%0d wdata=%h expected all 0",
                           i, busy, mem_rd_en, mem_wr_en, mem_addr, mem_wdata);
      end
    end
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (outs_nonzero() !== 1'b0) begin
        errors++; $display("FAIL reset_idle cyc=%0d outputs nonzero busy=%b done=%b rd=%b wr=%b expected all 0",
                           i, busy, done, mem_rd_en, mem_wr_en);
      end
    end
  endtask

  task automatic test_single_bit();
    fill_random();
    mem[0] = 25'h0000400;
    mem[1] = 25'h0000080;
    mem[2] = 25'h0000001;
    run_pass(0, 0, 0, 1'b0);
    checks++;
    if (mem[0] !== 25'h0000002) begin errors++; $display("FAIL single_bit10 got=%h exp=%h", mem[0], 25'h0000002); end
    checks++;
    if (mem[1] !== 25'h0000400) begin errors++; $display("FAIL single_bit7 got=%h exp=%h", mem[1], 25'h0000400); end
    checks++;
    if (mem[2] !== 25'h0000001) begin errors++; $display("FAIL single_bit0 got=%h exp=%h", mem[2], 25'h0000001); end
  endtask

  task automatic test_full_pass();
    fill_random();
    orig[5] = 25'h1FFFFFF;
    mem[5]  = 25'h1FFFFFF;
    run_pass(0, 0, 0, 1'b0);
    checks++;
    if (timed_out) begin errors++; $display("FAIL full_timeout busy never dropped within 400 cycles"); end
    checks++;
    if (rd_cyc.size() != 64) begin errors++; $display("FAIL full_rd_count got=%0d exp=64", rd_cyc.size()); end
    checks++;
    if (wr_cyc.size() != 64) begin errors++; $display("FAIL full_wr_count got=%0d exp=64", wr_cyc.size()); end
    for (int k = 0; k < rd_cyc.size(); k++) begin
      checks++;
      if (rd_adr[k] != k || rd_cyc[k] != 3*k+1) begin
        errors++; $display("FAIL full_read idx=%0d addr=%0d cyc=%0d exp addr=%0d cyc=%0d", k, rd_adr[k], rd_cyc[k], k, 3*k+1);
      end
    end
    for (int k = 0; k < wr_cyc.size(); k++) begin
      checks++;
      if (wr_adr[k] != k || wr_cyc[k] != 3*k+3 || wr_dat[k] !== inv_pi(orig[k])) begin
        errors++; $display("FAIL full_write idx=%0d addr=%0d cyc=%0d data=%h exp addr=%0d cyc=%0d data=%h",
                           k, wr_adr[k], wr_cyc[k], wr_dat[k], k, 3*k+3, inv_pi(orig[k]));
      end
    end
    checks++;
    if (done_cyc.size() != 1 || done_cyc[0] != 193) begin
      errors++; $display("FAIL full_done count=%0d first=%0d exp count=1 cyc=193",
                         done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] : -1);
    end
    checks++;
    if (overlap != 0) begin errors++; $display("FAIL full_overlap rd&wr cycles=%0d exp=0", overlap); end
    checks++;
    if (end_cyc != 194) begin errors++; $display("FAIL full_idle_cycle got=%0d exp=194", end_cyc); end
    checks++;
    if (mem[5] !== 25'h1FFFFFF) begin errors++; $display("FAIL full_all_ones got=%h exp=1ffffff", mem[5]); end
    for (int k = 0; k < 64; k++) begin
      checks++;
      if (mem[k] !== inv_pi(orig[k])) begin
        errors++; $display("FAIL full_mem slice=%0d got=%h exp=%h", k, mem[k], inv_pi(orig[k]));
      end
    end
  endtask

  task automatic test_round_trip();
    for (int k = 0; k < 64; k++) begin
      orig[k] = 25'($urandom);
      mem[k]  = fwd_pi(orig[k]);
    end
    run_pass(0, 0, 0, 1'b0);
    for (int k = 0; k < 64; k++) begin
      checks++;
      if (mem[k] !== orig[k]) begin
        errors++; $display("FAIL round_trip slice=%0d got=%h exp=%h", k, mem[k], orig[k]);
      end
    end
  endtask

  task automatic test_start_ignored();
    fill_random();
    run_pass(0, 50, 150, 1'b0);
    checks++;
    if (rd_cyc.size() != 64 || wr_cyc.size() != 64) begin
      errors++; $display("FAIL ignore_counts rd=%0d wr=%0d exp 64/64", rd_cyc.size(), wr_cyc.size());
    end
    checks++;
    if (done_cyc.size() != 1 || done_cyc[0] != 193) begin
      errors++; $display("FAIL ignore_done count=%0d first=%0d exp count=1 cyc=193",
                         done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] : -1);
    end
    checks++;
    if (end_cyc != 194) begin errors++; $display("FAIL ignore_idle_cycle got=%0d exp=194", end_cyc); end
  endtask

  task automatic test_mid_reset();
    fill_random();
    run_pass(100, 0, 0, 1'b0);
    checks++;
    if (abort_nz !== 1'b0) begin errors++; $display("FAIL abort_outputs nonzero after rst got=1 exp=0"); end
    checks++;
    if (wr_cyc.size() != 33 || rd_cyc.size() != 34) begin
      errors++; $display("FAIL abort_counts rd=%0d wr=%0d exp rd=34 wr=33", rd_cyc.size(), wr_cyc.size());
    end
    checks++;
    if (done_cyc.size() != 0) begin errors++; $display("FAIL abort_done pulses=%0d exp=0", done_cyc.size()); end
    repeat (2) @(posedge clk);
    for (int k = 0; k < 64; k++) begin
      checks++;
      if (mem[k] !== ((k < 33) ? inv_pi(orig[k]) : orig[k])) begin
        errors++; $display("FAIL abort_mem slice=%0d got=%h exp=%h", k, mem[k], (k < 33) ? inv_pi(orig[k]) : orig[k]);
      end
    end
    @(negedge clk);
    checks++;
    if (outs_nonzero() !== 1'b0) begin errors++; $display("FAIL abort_quiet outputs nonzero during rst exp all 0"); end
    rst = 1'b0;
    for (int k = 0; k < 64; k++) orig[k] = mem[k];
    run_pass(0, 0, 0, 1'b0);
    checks++;
    if (done_cyc.size() != 1 || done_cyc[0] != 193 || wr_cyc.size() != 64) begin
      errors++; $display("FAIL abort_restart done_count=%0d wr=%0d exp done at 193 with 64 writes",
                         done_cyc.size(), wr_cyc.size());
    end
    checks++;
    if (mem[40] !== inv_pi(orig[40])) begin
      errors++; $display("FAIL abort_restart_data got=%h exp=%h", mem[40], inv_pi(orig[40]));
    end
  endtask

  task automatic test_back_to_back();
    fill_random();
    run_pass(0, 0, 0, 1'b1);
    checks++;
    if (done_cyc.size() != 1 || done_cyc[0] != 193) begin
      errors++; $display("FAIL b2b_done count=%0d first=%0d exp cyc=193",
                         done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] : -1);
    end
    checks++;
    if (rd_cyc.size() != 65 || rd_cyc[rd_cyc.size()-1] != 195 || rd_adr[rd_adr.size()-1] != 0) begin
      errors++; $display("FAIL b2b_relaunch reads=%0d last_cyc=%0d last_addr=%0d exp reads=65 cyc=195 addr=0",
                         rd_cyc.size(), (rd_cyc.size() > 0) ? rd_cyc[rd_cyc.size()-1] : -1,
                         (rd_adr.size() > 0) ? rd_adr[rd_adr.size()-1] : -1);
    end
    start = 1'b0;
    do_reset();
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    test_reset();
    test_single_bit();
    test_full_pass();
    test_round_trip();
    test_start_ignored();
    test_mid_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
